// File: rtl/pixel_ram_arbiter_if.sv
// Client-side bundle for pixel_ram_arbiter: per-client read and write request/grant
// signals, plus the tagged read-return path.
interface pixel_ram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic [1:0]        rd_req;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [1:0]        rd_gnt;
    logic [1:0]        rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;

    modport master (
        output rd_req, rd_addr0, rd_addr1, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr0, rd_addr1, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/pixel_ram_arbiter.sv
// Two-client round-robin arbiter in front of the dual-port pixel RAM. The read and
// write ports are arbitrated independently, and read returns are steered by a tag pipeline.
module pixel_ram_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    pixel_ram_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] rdaddress,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q
);
    localparam int DEPTH = 1 + RAM_LAT;

    // Index 0 is the read port, index 1 is the write port.
    logic [1:0][1:0] w_req;
    logic [1:0]      w_rd_gnt;
    logic [1:0]      w_wr_gnt;

    assign w_req = {bus.wr_req, bus.rd_req};

    for (genvar gi = 0; gi < 2; gi++) begin : g_arb
        logic [1:0] w_gnt;
        logic       r_prio;   // 0 favours client 0, 1 favours client 1

        always_comb begin
            w_gnt = 2'b00;
            if (!reset) begin
                case (w_req[gi])
                    2'b01:   w_gnt = 2'b01;
                    2'b10:   w_gnt = 2'b10;
                    2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
                    default: w_gnt = 2'b00;
                endcase
            end
        end

        // After any grant, priority moves to the client that was not served.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_prio <= 1'b0;
            end else if (w_gnt[0]) begin
                r_prio <= 1'b1;
            end else if (w_gnt[1]) begin
                r_prio <= 1'b0;
            end
        end
    end

    assign w_rd_gnt   = g_arb[0].w_gnt;
    assign w_wr_gnt   = g_arb[1].w_gnt;
    assign bus.rd_gnt = w_rd_gnt;
    assign bus.wr_gnt = w_wr_gnt;

    // Each pipeline stage holds the one-hot owner of the read in flight; zero marks a bubble.
    logic [DEPTH-1:0][1:0] r_tag;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag     <= '0;
            rdaddress <= '0;
        end else begin
            r_tag <= {r_tag[DEPTH-2:0], w_rd_gnt};
            if (w_rd_gnt[1]) begin
                rdaddress <= bus.rd_addr1;
            end else if (w_rd_gnt[0]) begin
                rdaddress <= bus.rd_addr0;
            end
        end
    end

    assign bus.rd_valid = r_tag[DEPTH-1];
    assign bus.rd_data  = q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wren      <= 1'b0;
            wraddress <= '0;
            data      <= '0;
        end else begin
            wren <= |w_wr_gnt;
            if (w_wr_gnt[1]) begin
                wraddress <= bus.wr_addr1;
                data      <= bus.wr_data1;
            end else if (w_wr_gnt[0]) begin
                wraddress <= bus.wr_addr0;
                data      <= bus.wr_data0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter: two instances (RAM_LAT 1 and 3) sharing one pixel
// memory model, checked against hand-computed grants, latencies and data.
module tb_pixel_ram_arbiter;
    localparam int AW = 18;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    pixel_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    logic [AW-1:0] rdaddress1, wraddress1, rdaddress3, wraddress3;
    logic [DW-1:0] data1, data3, q1, q3;
    logic          wren1, wren3;

    pixel_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_dut (
        .clock(clk), .reset(rst), .bus(bus1),
        .rdaddress(rdaddress1), .wraddress(wraddress1), .data(data1), .wren(wren1), .q(q1)
    );

    pixel_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_dut_lat3 (
        .clock(clk), .reset(rst), .bus(bus3),
        .rdaddress(rdaddress3), .wraddress(wraddress3), .data(data3), .wren(wren3), .q(q3)
    );

    // Pixel memory model: one write port, a 1-cycle read for u_dut and a 3-cycle read for u_dut_lat3.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] q3_pipe [3];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wren1) mem[wraddress1] <= data1;
        q1         <= mem[rdaddress1];
        q3_pipe[0] <= mem[rdaddress3];
        q3_pipe[1] <= q3_pipe[0];
        q3_pipe[2] <= q3_pipe[1];
    end
    assign q3 = q3_pipe[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [AW-1:0] pre_addr [7] = '{18'h10, 18'h11, 18'h12, 18'h20, 18'h21, 18'h22, 18'h05};
    logic [DW-1:0] pre_data [7] = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1, 8'hD2, 8'h5A};

    initial begin
        rst = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus1.rd_req = 2'b00; bus1.rd_addr0 = '0; bus1.rd_addr1 = '0;
        bus1.wr_req = 2'b00; bus1.wr_addr0 = '0; bus1.wr_addr1 = '0;
        bus1.wr_data0 = '0; bus1.wr_data1 = '0;
        bus3.rd_req = 2'b00; bus3.rd_addr0 = '0; bus3.rd_addr1 = '0;
        bus3.wr_req = 2'b00; bus3.wr_addr0 = '0; bus3.wr_addr1 = '0;
        bus3.wr_data0 = '0; bus3.wr_data1 = '0;

        for (int i = 0; i < 7; i++) begin
            cyc();
            pl_en = 1'b1; pl_addr = pre_addr[i]; pl_data = pre_data[i];
        end
        cyc();
        pl_en = 1'b0;

        // Reset with both clients requesting on both ports.
        bus1.rd_req = 2'b11; bus1.rd_addr0 = 18'h10; bus1.rd_addr1 = 18'h20;
        bus1.wr_req = 2'b11; bus1.wr_addr0 = 18'h30; bus1.wr_data0 = 8'h77;
        bus1.wr_addr1 = 18'h31; bus1.wr_data1 = 8'h66;
        for (int i = 0; i < 2; i++) begin
            cyc(); mid();
            chk("rst_rd_gnt", bus1.rd_gnt, 2'b00);
            chk("rst_wr_gnt", bus1.wr_gnt, 2'b00);
            chk("rst_wren", wren1, 1'b0);
            chk("rst_rd_valid", bus1.rd_valid, 2'b00);
            chk("rst_rdaddress", rdaddress1, 18'h0);
        end
        cyc(); rst = 1'b0; mid();
        chk("post_rst_rd_gnt", bus1.rd_gnt, 2'b01);
        chk("post_rst_wr_gnt", bus1.wr_gnt, 2'b01);
        cyc(); bus1.rd_req = 2'b00; bus1.wr_req = 2'b00; mid();
        chk("post_rst_wren", wren1, 1'b1);
        chk("post_rst_wraddress", wraddress1, 18'h30);
        chk("post_rst_data", data1, 8'h77);
        chk("post_rst_rdaddress", rdaddress1, 18'h10);
        cyc(); mid();
        chk("post_rst_valid", bus1.rd_valid, 2'b01);
        chk("post_rst_rd_data", bus1.rd_data, 8'hC0);
        chk("post_rst_wren_off", wren1, 1'b0);

        // Client 1 writes AA@0 and BB@1; client 0 reads them back.
        cyc(); bus1.wr_req = 2'b10; bus1.wr_addr1 = 18'h0; bus1.wr_data1 = 8'hAA; mid();
        chk("wr0_gnt", bus1.wr_gnt, 2'b10);
        cyc(); bus1.wr_addr1 = 18'h1; bus1.wr_data1 = 8'hBB; mid();
        chk("wr1_gnt", bus1.wr_gnt, 2'b10);
        cyc(); bus1.wr_req = 2'b00;
        cyc(); cyc();
        cyc(); bus1.rd_req = 2'b01; bus1.rd_addr0 = 18'h0; mid();
        chk("rd0_gnt", bus1.rd_gnt, 2'b01);
        cyc(); bus1.rd_addr0 = 18'h1; mid();
        chk("rd1_gnt", bus1.rd_gnt, 2'b01);
        chk("rd0_not_early", bus1.rd_valid, 2'b00);
        cyc(); bus1.rd_req = 2'b00; mid();
        chk("rd0_valid", bus1.rd_valid, 2'b01);
        chk("rd0_data", bus1.rd_data, 8'hAA);
        cyc(); mid();
        chk("rd1_valid", bus1.rd_valid, 2'b01);
        chk("rd1_data", bus1.rd_data, 8'hBB);
        cyc(); mid();
        chk("rd_idle_valid", bus1.rd_valid, 2'b00);

        // Contention: alternating grants and returns after a fresh reset.
        cyc(); rst = 1'b1;
        cyc(); cyc(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            if (i < 6) begin
                bus1.rd_req   = 2'b11;
                bus1.rd_addr0 = 18'h10 + AW'((i + 1) / 2);
                bus1.rd_addr1 = 18'h20 + AW'(i / 2);
            end else begin
                bus1.rd_req = 2'b00;
            end
            mid();
            if (i < 6) chk($sformatf("cont_gnt%0d", i), bus1.rd_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i >= 2) begin
                chk($sformatf("cont_valid%0d", i - 2), bus1.rd_valid,
                    ((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
                chk($sformatf("cont_data%0d", i - 2), bus1.rd_data,
                    (((i - 2) % 2 == 0) ? 8'hC0 : 8'hD0) + 8'((i - 2) / 2));
            end
        end

        // Simultaneous read by client 0 and write by client 1.
        cyc();
        bus1.rd_req = 2'b01; bus1.rd_addr0 = 18'h05;
        bus1.wr_req = 2'b10; bus1.wr_addr1 = 18'h06; bus1.wr_data1 = 8'h33;
        mid();
        chk("sim_rd_gnt", bus1.rd_gnt, 2'b01);
        chk("sim_wr_gnt", bus1.wr_gnt, 2'b10);
        cyc(); bus1.rd_req = 2'b00; bus1.wr_req = 2'b00; mid();
        chk("sim_wren", wren1, 1'b1);
        cyc(); mid();
        chk("sim_valid", bus1.rd_valid, 2'b01);
        chk("sim_rd_data", bus1.rd_data, 8'h5A);
        cyc(); cyc();
        cyc(); bus1.rd_req = 2'b01; bus1.rd_addr0 = 18'h06; mid();
        chk("rb_gnt", bus1.rd_gnt, 2'b01);
        cyc(); bus1.rd_req = 2'b00;
        cyc(); mid();
        chk("rb_valid", bus1.rd_valid, 2'b01);
        chk("rb_data", bus1.rd_data, 8'h33);

        // Reset in the cycle after a read grant drops that read.
        cyc(); bus1.rd_req = 2'b01; bus1.rd_addr0 = 18'h10; mid();
        chk("mid_gnt", bus1.rd_gnt, 2'b01);
        cyc(); bus1.rd_req = 2'b10; rst = 1'b1; mid();
        chk("mid_rst_gnt", bus1.rd_gnt, 2'b00);
        cyc(); bus1.rd_req = 2'b00; rst = 1'b0; mid();
        chk("mid_drop_valid0", bus1.rd_valid, 2'b00);
        cyc(); mid();
        chk("mid_drop_valid1", bus1.rd_valid, 2'b00);

        // RAM_LAT = 3 instance: return exactly 4 cycles after the grant.
        cyc(); bus3.rd_req = 2'b01; bus3.rd_addr0 = 18'h11; mid();
        chk("lat3_gnt", bus3.rd_gnt, 2'b01);
        for (int j = 1; j <= 4; j++) begin
            cyc(); bus3.rd_req = 2'b00; mid();
            if (j < 4) begin
                chk($sformatf("lat3_early%0d", j), bus3.rd_valid, 2'b00);
            end else begin
                chk("lat3_valid", bus3.rd_valid, 2'b01);
                chk("lat3_data", bus3.rd_data, 8'hC1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
